rv32i_mc_controller: RTL and testbench
======================================

# rv32i_mc_controller

Multicycle control unit for the RV32I core: the decode end of the instruction encoding the datapath executes. Each cycle it takes opcode/funct fields from the instruction register and the ALU Zero flag, and sequences a Moore FSM through fetch, decode, execute, memory and writeback steps. It drives every datapath enable and mux select, letting the datapath share one ALU and one memory port across cycles.

## Interface
Parameters: none (encodings fixed below).

- clk  in  1  core clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU result == 0
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register / OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Illegal  out  1  one-cycle pulse: unsupported opcode
- state  out  4  current FSM state, debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11–15 go to FETCH next cycle.
- Transitions: FETCH→DECODE. DECODE: lw 0000011 / sw 0100011 → MEMADR; R 0110011 → EXECUTER; I-ALU 0010011 → EXECUTEI; jal 1101111 → JAL; branch 1100011 → BEQ; any other op → FETCH with Illegal = 1 in DECODE. MEMADR: op[5] = 0 → MEMREAD, else → MEMWRITE. MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH. EXECUTER, EXECUTEI, JAL → ALUWB→FETCH. BEQ→FETCH.
- Per-state outputs (unlisted fields 0; internal ALUOp 00 add / 01 sub / 10 funct):
  - FETCH: IRWrite, PCUpdate, AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch target).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate.
  - ALUWB: ResultSrc 00, RegWrite.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch.
- PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])); beq (000) and bne (001) both supported.
- ALU decoder: ALUOp 00 → 000; 01 → 001; 10 → by funct3: 000 → 001 if (op[5] & funct7b5), else 000; 010 → 101; 110 → 011; 111 → 010; other funct3 → 000.
- ImmSrc from op: lw/I-ALU 00, sw 01, branch 10, jal 11, other 00.

## Timing
- state is registered. Datapath-control outputs are Moore, decoded from state. Exceptions: PCWrite depends on Zero and funct3 in BEQ; ALUControl and ImmSrc are combinational from op/funct3/funct7b5.
- op/funct fields are required stable from DECODE until return to FETCH; IRWrite pulses only in FETCH.
- CPI: lw 5, sw 4, R/I-ALU 4, jal 4, branch 3, illegal 2.
- Reset: rst_n low forces state = FETCH asynchronously. While rst_n is low, PCWrite, IRWrite, RegWrite, MemWrite and Illegal are forced to 0. Other outputs show FETCH values: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, ALUControl 000, state 0.
- Reset mid-instruction aborts it; no RegWrite or MemWrite is issued after rst_n falls. The first rising edge after rst_n rises leaves FETCH.

## Test plan
- Reset: rst_n low mid-MEMWB → state 0 immediately, RegWrite 0; after release, FETCH has IRWrite = 1, PCWrite = 1, ALUSrcB = 10.
- addi x5,x0,3 (op 0010011, f3 000): states 0,1,8,7,0; ALUControl 000 in EXECUTEI; RegWrite = 1 only in ALUWB; ImmSrc 00.
- sub (op 0110011, f3 000, funct7b5 1) → ALUControl 001 in EXECUTER; slt (f3 010) → 101; and (111) → 010; or (110) → 011.
- lw: states 0,1,2,3,4,0, AdrSrc 1 in MEMREAD, ResultSrc 01 + RegWrite in MEMWB. sw: states 0,1,2,5,0, MemWrite = 1 for exactly one cycle, ImmSrc 01.
- beq with Zero = 1 → PCWrite = 1 in BEQ; Zero = 0 → PCWrite = 0; bne (f3 001) inverts both cases. jal: states 0,1,9,7,0, PCWrite in JAL, ImmSrc 11.
- op 0110111 (unsupported) → Illegal = 1 for one cycle in DECODE, next state FETCH; no RegWrite or MemWrite asserted.

Source files
------------

// File: rtl/rv32i_mc_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing a shared-ALU,
// single-memory-port datapath, plus ALU and immediate decoders.
module rv32i_mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       is_ld;
    logic       is_st;
    logic       is_mem;
    logic       is_r;
    logic       is_i;
    logic       is_jal;
    logic       is_br;
    logic       legal;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] alu_op;

    assign is_ld  = (op == OP_LW);
    assign is_st  = (op == OP_SW);
    assign is_mem = is_ld | is_st;
    assign is_r   = (op == OP_R);
    assign is_i   = (op == OP_I);
    assign is_jal = (op == OP_JAL);
    assign is_br  = (op == OP_BR);
    assign legal  = is_mem | is_r | is_i | is_jal | is_br;
    assign state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:  state_d = S_MEMADR;
                    is_r:    state_d = S_EXECUTER;
                    is_i:    state_d = S_EXECUTEI;
                    is_jal:  state_d = S_JAL;
                    is_br:   state_d = S_BEQ;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated so nothing commits while reset is held.
    assign PCWrite  = rst_n & (pc_update | (branch & (Zero ^ funct3[0])));
    assign IRWrite  = rst_n & ir_write;
    assign RegWrite = rst_n & reg_write;
    assign MemWrite = rst_n & mem_write;
    assign Illegal  = rst_n & (state_q == S_DECODE) & ~legal;

    always_comb begin
        ALUControl = 3'b000;
        unique case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        unique case (1'b1)
            is_ld | is_i: ImmSrc = 2'b00;
            is_st:        ImmSrc = 2'b01;
            is_br:        ImmSrc = 2'b10;
            is_jal:       ImmSrc = 2'b11;
            default:      ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Scoreboard bench for rv32i_mc_controller: expected per-cycle control
// bundles come from an instruction-level reference model.
module tb_rv32i_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    rv32i_mc_controller dut (
        .clk(clk),
        .rst_n(rst_n),
        .op(op),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .Zero(Zero),
        .PCWrite(PCWrite),
        .AdrSrc(AdrSrc),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite),
        .ImmSrc(ImmSrc),
        .ALUControl(ALUControl),
        .Illegal(Illegal),
        .state(state)
    );

    typedef enum int {K_LW, K_SW, K_R, K_I, K_JAL, K_BR, K_ILL} kind_t;

    logic [20:0] act;
    logic [20:0] sb[$];
    int          total = 0;
    int          bad = 0;

    assign act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, RegWrite, ImmSrc, ALUControl, Illegal};

    function automatic kind_t classify(logic [6:0] o);
        case (o)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1101111: return K_JAL;
            7'b1100011: return K_BR;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(kind_t k);
        case (k)
            K_SW:    return 2'b01;
            K_BR:    return 2'b10;
            K_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Arithmetic ops: only register-register form honours the sub bit.
    function automatic logic [2:0] arith(kind_t k, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (k == K_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [20:0] step(int st, kind_t k, logic [2:0] f3,
                                         logic f7, logic z);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sbs;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sbs = 0; alu = 0;
        case (st)
            0:  begin irw = 1; pcw = 1; sbs = 2; rs = 2; end
            1:  begin sa = 1; sbs = 1; ill = (k == K_ILL); end
            2:  begin sa = 2; sbs = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; alu = arith(k, f3, f7); end
            7:  rw = 1;
            8:  begin sa = 2; sbs = 1; alu = arith(k, f3, f7); end
            9:  begin sa = 1; sbs = 2; pcw = 1; end
            10: begin sa = 2; alu = 3'b001; pcw = z ^ f3[0]; end
            default: ;
        endcase
        return {4'(st), pcw, adr, mw, irw, rs, sa, sbs, rw, imm_of(k), alu, ill};
    endfunction

    function automatic logic [20:0] rst_rec(logic [6:0] o);
        return {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0,
                imm_of(classify(o)), 3'b000, 1'b0};
    endfunction

    // Called at posedge+1; pushes one record per cycle it spans.
    task automatic issue(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
        kind_t k;
        int    seq[$];
        k = classify(o);
        case (k)
            K_LW:    seq = '{0, 1, 2, 3, 4};
            K_SW:    seq = '{0, 1, 2, 5};
            K_R:     seq = '{0, 1, 6, 7};
            K_I:     seq = '{0, 1, 8, 7};
            K_JAL:   seq = '{0, 1, 9, 7};
            K_BR:    seq = '{0, 1, 10};
            default: seq = '{0, 1};
        endcase
        rst_n = 1; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        foreach (seq[i]) sb.push_back(step(seq[i], k, f3, f7, z));
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(int n);
        rst_n = 0;
        repeat (n) begin
            sb.push_back(rst_rec(op));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_in_memwb();
        rst_n = 1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 0; Zero = 0;
        for (int s = 0; s < 4; s++) sb.push_back(step(s, K_LW, 3'b010, 0, 0));
        repeat (4) @(posedge clk);
        #2;
        hold_reset(2);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [20:0] e;
            e = sb.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL ctrl t=%0t state=%0d got=%h want=%h",
                         $time, state, act, e);
            end
        end
    end

    initial begin
        logic [6:0] o;
        rst_n = 0; op = 7'b0010011; funct3 = 0; funct7b5 = 0; Zero = 0;
        @(posedge clk);
        #1;
        hold_reset(2);
        issue(7'b0010011, 3'b000, 1'b0, 1'b0);
        issue(7'b0010011, 3'b000, 1'b1, 1'b0);
        issue(7'b0110011, 3'b000, 1'b1, 1'b0);
        issue(7'b0110011, 3'b000, 1'b0, 1'b1);
        issue(7'b0110011, 3'b010, 1'b0, 1'b0);
        issue(7'b0110011, 3'b111, 1'b0, 1'b0);
        issue(7'b0110011, 3'b110, 1'b0, 1'b0);
        issue(7'b0000011, 3'b010, 1'b0, 1'b0);
        issue(7'b0100011, 3'b010, 1'b0, 1'b0);
        issue(7'b1100011, 3'b000, 1'b0, 1'b1);
        issue(7'b1100011, 3'b000, 1'b0, 1'b0);
        issue(7'b1100011, 3'b001, 1'b0, 1'b1);
        issue(7'b1100011, 3'b001, 1'b0, 1'b0);
        issue(7'b1101111, 3'b000, 1'b0, 1'b0);
        issue(7'b0110111, 3'b000, 1'b0, 1'b0);
        reset_in_memwb();
        issue(7'b0010011, 3'b111, 1'b0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 6))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1101111;
                5: o = 7'b1100011;
                default: begin
                    o = 7'($urandom);
                    while (classify(o) != K_ILL) o = 7'($urandom);
                end
            endcase
            if ($urandom_range(0, 19) == 0) hold_reset(1);
            issue(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
